// File: rtl/mau_pkg.sv
// Shared encodings for the memory access unit: op codes, bus sizes, FSM states.
// Helper functions classify ops so decode stays in one place.
package mau_pkg;

    typedef enum logic [3:0] {
        MOP_NONE = 4'd0,
        MOP_LB   = 4'd1,
        MOP_LBU  = 4'd2,
        MOP_LH   = 4'd3,
        MOP_LHU  = 4'd4,
        MOP_LW   = 4'd5,
        MOP_LWL  = 4'd6,
        MOP_LWR  = 4'd7,
        MOP_SB   = 4'd8,
        MOP_SH   = 4'd9,
        MOP_SW   = 4'd10,
        MOP_SWL  = 4'd11,
        MOP_SWR  = 4'd12
    } mop_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic is_load(input mop_e op);
        return op inside {MOP_LB, MOP_LBU, MOP_LH, MOP_LHU, MOP_LW, MOP_LWL, MOP_LWR};
    endfunction

    function automatic logic is_store(input mop_e op);
        return op inside {MOP_SB, MOP_SH, MOP_SW, MOP_SWL, MOP_SWR};
    endfunction

endpackage

// File: rtl/mau_lane_fmt.sv
// Combinational byte-lane logic: store strobes/data/size and load extract/merge.
// Zero latency, no flow control; shared with the cache path.
module mau_lane_fmt
    import mau_pkg::*;
(
    input  mop_e        i_st_op,
    input  logic [1:0]  i_st_a,
    input  logic [31:0] i_st_rt,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [1:0]  o_size,
    input  mop_e        i_ld_op,
    input  logic [1:0]  i_ld_a,
    input  logic [31:0] i_ld_rt,
    input  logic [31:0] i_ld_mem,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_ld_mem[{i_ld_a, 3'b000} +: 8];
    assign w_half = i_ld_a[1] ? i_ld_mem[31:16] : i_ld_mem[15:0];

    always_comb begin
        o_wstrb = 4'b0000;
        o_wdata = 32'h0;
        o_size  = SIZE_WORD;
        case (i_st_op)
            MOP_LB, MOP_LBU: o_size = SIZE_BYTE;
            MOP_LH, MOP_LHU: o_size = SIZE_HALF;
            MOP_SB: begin
                o_size  = SIZE_BYTE;
                o_wstrb = 4'b0001 << i_st_a;
                o_wdata = {4{i_st_rt[7:0]}};
            end
            MOP_SH: begin
                o_size  = SIZE_HALF;
                o_wstrb = i_st_a[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_st_rt[15:0]}};
            end
            MOP_SW: begin
                o_wstrb = 4'b1111;
                o_wdata = i_st_rt;
            end
            // Left/right stores only touch the bytes on their side of the boundary.
            MOP_SWL: begin
                o_wstrb = 4'b1111 >> (2'd3 - i_st_a);
                o_wdata = i_st_rt >> {2'd3 - i_st_a, 3'b000};
            end
            MOP_SWR: begin
                o_wstrb = 4'b1111 << i_st_a;
                o_wdata = i_st_rt << {i_st_a, 3'b000};
            end
            default: ;
        endcase
    end

    always_comb begin
        o_ld_data = i_ld_mem;
        case (i_ld_op)
            MOP_LB:  o_ld_data = {{24{w_byte[7]}}, w_byte};
            MOP_LBU: o_ld_data = {24'h0, w_byte};
            MOP_LH:  o_ld_data = {{16{w_half[15]}}, w_half};
            MOP_LHU: o_ld_data = {16'h0, w_half};
            MOP_LWL: begin
                case (i_ld_a)
                    2'd0:    o_ld_data = {i_ld_mem[7:0],  i_ld_rt[23:0]};
                    2'd1:    o_ld_data = {i_ld_mem[15:0], i_ld_rt[15:0]};
                    2'd2:    o_ld_data = {i_ld_mem[23:0], i_ld_rt[7:0]};
                    default: o_ld_data = i_ld_mem;
                endcase
            end
            MOP_LWR: begin
                case (i_ld_a)
                    2'd0:    o_ld_data = i_ld_mem;
                    2'd1:    o_ld_data = {i_ld_rt[31:24], i_ld_mem[31:8]};
                    2'd2:    o_ld_data = {i_ld_rt[31:16], i_ld_mem[31:16]};
                    default: o_ld_data = {i_ld_rt[31:8],  i_ld_mem[31:24]};
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage load/store unit: decodes, checks alignment, runs the req/addr_ok/data_ok bus handshake.
// Min 3 cycles accept-to-result; holds the M stage via stall, result held until m_allowin.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter bit          UNALIGNED_EN = 1'b1,
    parameter bit          HOLD_RESULT  = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    input  logic [3:0]        i_mem_op,
    input  logic [ADDR_W-1:0] i_vaddr,
    input  logic [31:0]       i_rt_wdata,
    input  logic              i_flush,
    input  logic              i_m_allowin,
    output logic              o_stall,
    output logic [31:0]       o_rdata,
    output logic              o_rdata_valid,
    output logic              o_addr_err_l,
    output logic              o_addr_err_s,
    output logic              o_data_req,
    output logic              o_data_wr,
    output logic [1:0]        o_data_size,
    output logic [ADDR_W-1:0] o_data_addr,
    output logic [3:0]        o_data_wstrb,
    output logic [31:0]       o_data_wdata,
    input  logic              i_data_addr_ok,
    input  logic [31:0]       i_data_rdata,
    input  logic              i_data_data_ok
);

    state_e            r_state;
    state_e            w_state_nxt;
    mop_e              w_op;
    mop_e              r_op;
    logic [1:0]        r_a;
    logic [31:0]       r_rt;
    logic              r_cancel;
    logic [ADDR_W-1:0] r_data_addr;
    logic [3:0]        r_wstrb;
    logic [31:0]       r_wdata;
    logic [1:0]        r_size;
    logic              r_wr;
    logic [31:0]       r_rdata;

    logic              w_mis_l;
    logic              w_mis_s;
    logic              w_done_exit;
    logic              w_slot;
    logic              w_accept;
    logic              w_busy;
    logic [3:0]        w_wstrb;
    logic [31:0]       w_wdata;
    logic [1:0]        w_size;
    logic [31:0]       w_ld_data;

    assign w_op = mop_e'(i_mem_op);

    always_comb begin
        w_mis_l = 1'b0;
        w_mis_s = 1'b0;
        case (w_op)
            MOP_LW:           w_mis_l = |i_vaddr[1:0];
            MOP_LH, MOP_LHU:  w_mis_l = i_vaddr[0];
            MOP_LWL, MOP_LWR: w_mis_l = !UNALIGNED_EN;
            MOP_SW:           w_mis_s = |i_vaddr[1:0];
            MOP_SH:           w_mis_s = i_vaddr[0];
            MOP_SWL, MOP_SWR: w_mis_s = !UNALIGNED_EN;
            default: ;
        endcase
    end

    // A new op may enter from IDLE or in the same cycle DONE retires its result.
    assign w_done_exit = (r_state == ST_DONE) && (!HOLD_RESULT || i_m_allowin);
    assign w_slot      = (r_state == ST_IDLE) || (w_done_exit && !i_flush);
    assign w_accept    = w_slot && i_req_valid && !i_flush && !w_mis_l && !w_mis_s
                       && (is_load(w_op) || is_store(w_op));
    assign w_busy      = !r_cancel && !i_flush;

    assign o_addr_err_l = w_slot && i_req_valid && !i_flush && w_mis_l;
    assign o_addr_err_s = w_slot && i_req_valid && !i_flush && w_mis_s;

    mau_lane_fmt u_lane_fmt (
        .i_st_op   (w_op),
        .i_st_a    (i_vaddr[1:0]),
        .i_st_rt   (i_rt_wdata),
        .o_wstrb   (w_wstrb),
        .o_wdata   (w_wdata),
        .o_size    (w_size),
        .i_ld_op   (r_op),
        .i_ld_a    (r_a),
        .i_ld_rt   (r_rt),
        .i_ld_mem  (i_data_rdata),
        .o_ld_data (w_ld_data)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_REQ;
            ST_REQ:  if (i_data_addr_ok) w_state_nxt = ST_WAIT;
            ST_WAIT: if (i_data_data_ok) w_state_nxt = w_busy ? ST_DONE : ST_IDLE;
            ST_DONE: begin
                if (i_flush) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_done_exit) begin
                    w_state_nxt = w_accept ? ST_REQ : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The bus may not withdraw a request, so a cancelled op keeps data_req until addr_ok.
    always_comb begin
        o_stall       = 1'b0;
        o_data_req    = 1'b0;
        o_rdata_valid = 1'b0;
        case (r_state)
            ST_IDLE: o_stall = w_accept;
            ST_REQ: begin
                o_data_req = 1'b1;
                o_stall    = w_busy;
            end
            ST_WAIT: o_stall = w_busy;
            ST_DONE: begin
                o_stall       = w_accept;
                o_rdata_valid = is_load(r_op) && !i_flush;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_op        <= MOP_NONE;
            r_a         <= 2'd0;
            r_rt        <= 32'h0;
            r_data_addr <= '0;
            r_wstrb     <= 4'b0000;
            r_wdata     <= 32'h0;
            r_size      <= SIZE_BYTE;
            r_wr        <= 1'b0;
            r_rdata     <= 32'h0;
            r_cancel    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op        <= w_op;
                r_a         <= i_vaddr[1:0];
                r_rt        <= i_rt_wdata;
                r_data_addr <= {i_vaddr[ADDR_W-1:2], 2'b00};
                r_wstrb     <= w_wstrb;
                r_wdata     <= w_wdata;
                r_size      <= w_size;
                r_wr        <= is_store(w_op);
            end
            if (r_state == ST_WAIT && i_data_data_ok && w_busy && is_load(r_op)) begin
                r_rdata <= w_ld_data;
            end
            if (w_state_nxt == ST_IDLE) begin
                r_cancel <= 1'b0;
            end else if ((r_state == ST_REQ || r_state == ST_WAIT) && i_flush) begin
                r_cancel <= 1'b1;
            end
        end
    end

    assign o_rdata      = r_rdata;
    assign o_data_wr    = r_wr;
    assign o_data_size  = r_size;
    assign o_data_addr  = r_data_addr;
    assign o_data_wstrb = r_wstrb;
    assign o_data_wdata = r_wdata;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sequential successor to the M-stage load/store formatter.
- Decodes a memory op, checks alignment, drives byte strobes and aligned write data, and runs an SRAM-like handshake (req/addr_ok/data_ok) to the data bus.
- Formats returned read data, including LWL/LWR merge, and holds the M stage until the access completes.
- Sits between the M stage and the data-side bus bridge.

Parameters:
ADDR_W, 32, address width; data_addr is always word-aligned, so the low 2 bits are 0.
UNALIGNED_EN, 1, 1 = support LWL/LWR/SWL/SWR; 0 = these ops raise addr_err_l/addr_err_s.
HOLD_RESULT, 1, 1 = latch the result until m_allowin; 0 = result is valid for one cycle only.

Ports:
clk in 1 clock
rst in 1 asynchronous active-high reset
req_valid in 1 M stage has a valid mem op this cycle
mem_op in 4 op code, MOP_* from package
vaddr in ADDR_W byte address
rt_wdata in 32 store data, and the old rt for LWL/LWR
flush in 1 exception/eret flush: cancel the current op
m_allowin in 1 next stage accepts the M result
stall out 1 hold the M stage
rdata out 32 formatted load result
rdata_valid out 1 load result valid
addr_err_l out 1 load address error (AdEL)
addr_err_s out 1 store address error (AdES)
data_req out 1 bus request
data_wr out 1 1 = write
data_size out 2 0 = byte, 1 = half, 2 = word
data_addr out ADDR_W word-aligned address
data_wstrb out 4 byte enables
data_wdata out 32 lane-aligned write data
data_addr_ok in 1 bus accepted the address
data_rdata in 32 bus read data
data_data_ok in 1 bus data phase complete

Behaviour:
- Reset: state IDLE; data_req, data_wr, stall, rdata_valid, addr_err_l, addr_err_s = 0; data_size = 0; data_addr, data_wstrb, data_wdata, rdata = 0.
- Error check in IDLE (combinational):
  - LW not aligned to 4 -> addr_err_l. LH/LHU with addr[0]=1 -> addr_err_l.
  - SW not aligned to 4 -> addr_err_s. SH with addr[0]=1 -> addr_err_s.
  - An errored op issues no bus request; stall = 0.
- States:
  - IDLE: if req_valid, no error and no flush -> latch op, addr, wdata and rt; go to REQ. stall = 1 from the same cycle.
  - REQ: data_req = 1 with stable outputs until data_addr_ok. On addr_ok -> WAIT.
  - WAIT: on data_data_ok -> DONE, capture the formatted result.
  - DONE: stall = 0, rdata_valid = 1 for loads. HOLD_RESULT = 1: stay until m_allowin, then IDLE. HOLD_RESULT = 0: return to IDLE next cycle.
- Latency: minimum 3 cycles when addr_ok arrives in the first REQ cycle and data_ok the cycle after.
- A new request is accepted in the same cycle DONE exits.
- Write lanes: SB = 4 copies of the byte; SH = 2 copies of the halfword; wstrb decoded from addr[1:0].
  - SWL, addr[1:0] 0/1/2/3: wstrb 0001/0011/0111/1111; data rt >> 24/16/8/0.
  - SWR, addr[1:0] 0/1/2/3: wstrb 1111/1110/1100/1000; data rt << 0/8/16/24.
  - Unaligned ops use data_size = 2.
- Read formatting: LB/LBU/LH/LHU select the lane and sign- or zero-extend. LW passes through.
  - LWL, a = 0/1/2/3: {m[7:0],rt[23:0]}, {m[15:0],rt[15:0]}, {m[23:0],rt[7:0]}, m.
  - LWR, a = 0/1/2/3: m, {rt[31:24],m[31:8]}, {rt[31:16],m[31:16]}, {rt[31:8],m[31:24]}.
- Flush:
  - In IDLE: the op is dropped.
  - In REQ: data_req stays asserted until addr_ok, because the bus protocol forbids withdrawal. A cancel flag is set; the unit completes WAIT, discards the data (rdata_valid = 0) and goes to IDLE.
  - In WAIT: cancel, same as REQ.
  - In DONE: go to IDLE immediately.
  - stall drops as soon as flush is seen; the cancelled access drains while a new req_valid is ignored until IDLE.
- Simultaneous addr_ok and data_ok in the same cycle: addr_ok is taken in REQ only; data_ok is honoured only in WAIT.
- Reset mid-transaction: everything returns to reset values; the bus bridge is reset by the same rst.

Decomposition:
- Package mau_pkg: MOP_* encodings (LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW, SWL, SWR, NONE), SIZE_* constants, state encoding.
- Sub-module mau_lane_fmt: combinational store lane/strobe generation and load formatting/merge, reusable by the cache path.

Test Plan:
- LB at 0x1003, bus returns 0x80FF_0000 -> rdata 0xFFFF_FF80. LBU at the same address -> 0x0000_0080.
- SH at 0x2002, rt 0x1234_ABCD -> wstrb 1100, wdata 0xABCD_ABCD, size 1. SW at 0x2001 -> addr_err_s, no data_req.
- LWL at 0x3001, rt 0x1111_2222, mem 0xAABB_CCDD -> rdata 0xCCDD_2222. LWR at 0x3002 -> 0x1111_AABB.
- addr_ok delayed 3 cycles, data_ok 2 cycles later -> stall high for 6 cycles, data_addr stable throughout.
- flush in WAIT -> stall drops, data_ok consumed, rdata_valid stays 0, next req issues after return to IDLE.
- HOLD_RESULT = 1 with m_allowin low for 4 cycles -> rdata 0x5A5A_5A5A held valid until m_allowin.
